// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 inverse-cipher sequencer: one inverse round per clock, round keys
// fetched from an external store with one-cycle latency. Define AES_DEC_BLK_CNT_EN for blk_cnt.
module aes_inv_cipher_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         abort,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef AES_DEC_BLK_CNT_EN
    ,
    output logic [31:0]  blk_cnt
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WHITEN = 3'd1;
    localparam logic [2:0] ROUND  = 3'd2;
    localparam logic [2:0] FINAL  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]   fsm_q;
    logic [3:0]   rnd_q;
    logic [127:0] st_q;
    logic [127:0] isr_isb;
    logic [127:0] key_add;
    logic [127:0] round_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box: undo the affine map, then GF(2^8) inverse as b^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        logic [7:0] sq;
        logic [7:0] acc;
        b   = {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
        sq  = b;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ROUND and FINAL share the InvShiftRows/InvSubBytes/AddRoundKey path.
    assign isr_isb   = inv_sub_bytes(inv_shift_rows(st_q));
    assign key_add   = isr_isb ^ rk_data;
    assign round_out = inv_mix_cols(key_add);

    assign in_ready = (fsm_q == IDLE);
    assign busy     = (fsm_q == WHITEN) || (fsm_q == ROUND) || (fsm_q == FINAL);

    // Address for the key needed one cycle later, given the one-cycle store latency.
    always_comb begin
        rk_addr = 4'd10;
        case (fsm_q)
            WHITEN:  rk_addr = 4'd9;
            ROUND:   rk_addr = rnd_q - 4'd1;
            FINAL:   rk_addr = 4'd0;
            default: rk_addr = 4'd10;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            rnd_q     <= 4'd0;
            st_q      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (abort) begin
            fsm_q     <= IDLE;
            rnd_q     <= 4'd0;
            out_valid <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q  <= in_data;
                        fsm_q <= WHITEN;
                    end
                end
                WHITEN: begin
                    st_q  <= st_q ^ rk_data;
                    rnd_q <= 4'd9;
                    fsm_q <= ROUND;
                end
                ROUND: begin
                    st_q  <= round_out;
                    rnd_q <= rnd_q - 4'd1;
                    if (rnd_q == 4'd1) fsm_q <= FINAL;
                end
                FINAL: begin
                    out_data  <= key_add;
                    out_valid <= 1'b1;
                    fsm_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm_q     <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

`ifdef AES_DEC_BLK_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= 32'd0;
        end else if (!abort && (fsm_q == DONE) && out_ready) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: forward AES-128 reference model produces ciphertexts whose
// plaintexts are known; a cycle-level handshake model is compared against the DUT every cycle.
module tb_aes_inv_cipher_ctrl;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] rk_data = '0;
    logic [127:0] out_data;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [3:0]   rk_addr;
`ifdef AES_DEC_BLK_CNT_EN
    logic [31:0]  blk_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk [11];

    // model state: ph 0 = idle, 1..11 = processing cycles after accept, 12 = holding result
    int           ph = 0;
    logic [127:0] cur_pt = '0;
    logic [127:0] blk_pt = '0;
    logic [127:0] exp_out = '0;
    logic [31:0]  exp_cnt = '0;

    always #5 clk = ~clk;

    aes_inv_cipher_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .abort(abort), .rk_addr(rk_addr), .rk_data(rk_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef AES_DEC_BLK_CNT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    always @(posedge clk) rk_data <= (rk_addr <= 4'd10) ? rk[rk_addr] : '0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] xb;
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(xb, y[7:0]) == 8'h01) inv = y[7:0];
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Cycle-level behavioural model of the handshake/latency contract.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0;
            exp_out = '0;
            exp_cnt = '0;
        end else if (abort) begin
            ph = 0;
        end else if (ph == 0) begin
            if (in_valid) begin
                ph = 1;
                blk_pt = cur_pt;
            end
        end else if (ph < 11) begin
            ph = ph + 1;
        end else if (ph == 11) begin
            ph = 12;
            exp_out = blk_pt;
        end else if (out_ready) begin
            ph = 0;
            exp_cnt = exp_cnt + 32'd1;
        end
    end

    function automatic logic [3:0] exp_addr(input int p);
        if (p == 0 || p == 12) return 4'd10;
        if (p >= 10) return 4'd0;
        return 4'(10 - p);
    endfunction

    always @(negedge clk) begin
        chk("in_ready", in_ready, (ph == 0));
        chk("busy", busy, (ph >= 1 && ph <= 11));
        chk("out_valid", out_valid, (ph == 12));
        chk("rk_addr", rk_addr, exp_addr(ph));
        chk("out_data", out_data, exp_out);
`ifdef AES_DEC_BLK_CNT_EN
        chk("blk_cnt", blk_cnt, exp_cnt);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int acc);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("accept_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = ct;
        cur_pt   = pt;
        tick();
        in_valid = 1'b0;
        acc = cyc - 1;
    endtask

    task automatic wait_out(output int rise);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("out_valid_wait", out_valid, 1'b1);
        rise = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, r0;
        logic [127:0] pt, pt2, key;

        build_sbox();
        set_key(C1_KEY);
        chk("model_sbox00", sbox[0], 8'h63);
        chk("model_rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_c1_enc", encrypt(C1_PT), C1_CT);

        // asynchronous reset with no clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_rk_addr", rk_addr, 4'hA);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // FIPS-197 C.1
        out_ready = 1'b1;
        send(C1_CT, C1_PT, a0);
        tick();
        chk("c1_whiten_state", dut.st_q, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        wait_out(r0);
        chk("c1_latency", r0 - a0, 12);
        chk("c1_plaintext", out_data, C1_PT);
        tick();

        // backpressure
        out_ready = 1'b0;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send(encrypt(pt), pt, a0);
        wait_out(r0);
        for (int i = 0; i < 5; i++) begin
            pt2 = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            in_data  = encrypt(pt2);
            cur_pt   = pt2;
            tick();
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_data", out_data, pt);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_idle", in_ready, 1'b1);

        // back-to-back
        pt  = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        send(encrypt(pt), pt, a0);
        wait_out(r0);
        chk("b2b_first_pt", out_data, pt);
        send(encrypt(pt2), pt2, a1);
        chk("b2b_spacing", a1 - a0, 13);
        wait_out(r0);
        chk("b2b_second_pt", out_data, pt2);
        tick();

        // abort during ROUND with rnd = 5
        send(C1_CT, C1_PT, a0);
        repeat (5) tick();
        chk("abort_rnd", dut.rnd_q, 4'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_rk_addr", rk_addr, 4'd10);
        chk("abort_out_valid", out_valid, 1'b0);
        repeat (15) tick();
        // abort in IDLE blocks a simultaneous accept
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = C1_CT;
        cur_pt = C1_PT;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle_no_accept", in_ready, 1'b1);
        send(C1_CT, C1_PT, a0);
        wait_out(r0);
        chk("post_abort_pt", out_data, C1_PT);
        tick();

        // randomized keys, data and output backpressure
        for (int b = 0; b < 6; b++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            set_key(key);
            pt = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            send(encrypt(pt), pt, a0);
            wait_out(r0);
            chk("rand_latency", r0 - a0, 12);
            chk("rand_pt", out_data, pt);
            repeat ($urandom_range(0, 3)) tick();
            out_ready = 1'b1;
            tick();
        end

        // asynchronous reset in cycle 7 of a block
        set_key(C1_KEY);
        send(C1_CT, C1_PT, a0);
        repeat (6) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_data", out_data, 128'h0);
        chk("arst_rk_addr", rk_addr, 4'hA);
        chk("arst_busy", busy, 1'b0);
`ifdef AES_DEC_BLK_CNT_EN
        chk("arst_blk_cnt", blk_cnt, 32'd0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        repeat (14) tick();

`ifdef AES_DEC_BLK_CNT_EN
        // three blocks, one aborted
        send(C1_CT, C1_PT, a0);
        wait_out(r0);
        tick();
        send(C1_CT, C1_PT, a0);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        send(C1_CT, C1_PT, a0);
        wait_out(r0);
        tick();
        chk("cnt_two_blocks", blk_cnt, 32'd2);
        force dut.blk_cnt = 32'hFFFFFFFF;
        exp_cnt = 32'hFFFFFFFF;
        tick();
        release dut.blk_cnt;
        send(C1_CT, C1_PT, a0);
        wait_out(r0);
        tick();
        chk("cnt_wrap", blk_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
